// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator stepped by pix_en.
// Produces h/v counters, line/frame start strobes, and decoded
// sync/de/vblank delayed by 1+SYNC_DELAY pixel steps so they can be aligned
// with a pipelined pixel path.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int CW         = 10,
    parameter int SYNC_DELAY = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          vblank,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_BEG  = H_VISIBLE + H_FRONT;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_VISIBLE + V_FRONT;
    localparam int VS_END  = VS_BEG + V_SYNC;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    // Reject geometries the counters cannot hold and over-long delay lines.
    if ((64'd1 << CW) < 64'(H_TOTAL) || (64'd1 << CW) < 64'(V_TOTAL)) begin : g_bad_cw
        $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 15) begin : g_bad_delay
        $error("vga_timing_gen: SYNC_DELAY must be 0..15");
    end

    // One decoded timing sample; all fields are active-high internally.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic vb;
    } tim_t;

    // Compare in 32 bits so end-of-range constants never wrap at CW bits.
    logic [31:0] hc32;
    logic [31:0] vc32;
    tim_t        dec;

    // Stage 0 is the decode register; stage SYNC_DELAY drives the outputs.
    tim_t [SYNC_DELAY:0] dly_pipe;

    assign hc32 = 32'(hcount);
    assign vc32 = 32'(vcount);

    // Decode the current raster position.
    always_comb begin
        dec    = '0;
        dec.de = (hc32 < 32'(H_VISIBLE)) && (vc32 < 32'(V_VISIBLE));
        dec.hs = (hc32 >= 32'(HS_BEG)) && (hc32 < 32'(HS_END));
        dec.vs = (vc32 >= 32'(VS_BEG)) && (vc32 < 32'(VS_END));
        dec.vb = (vc32 >= 32'(V_VISIBLE));
    end

    // Raster counters and one-clk wrap strobes; strobes drop on the next clk
    // even when pix_en is sparse.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount      <= '0;
            vcount      <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                if (hcount == H_LAST) begin
                    hcount     <= '0;
                    line_start <= 1'b1;
                    if (vcount == V_LAST) begin
                        vcount      <= '0;
                        frame_start <= 1'b1;
                    end else begin
                        vcount <= vcount + 1'b1;
                    end
                end else begin
                    hcount <= hcount + 1'b1;
                end
            end
        end
    end

    // Decode register plus alignment delay, advancing only on pixel steps.
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_pipe <= '0;
        end else if (pix_en) begin
            dly_pipe[0] <= dec;
            for (int i = 1; i <= SYNC_DELAY; i++) begin
                dly_pipe[i] <= dly_pipe[i-1];
            end
        end
    end

    assign hsync  = dly_pipe[SYNC_DELAY].hs ? HS_POL : ~HS_POL;
    assign vsync  = dly_pipe[SYNC_DELAY].vs ? VS_POL : ~VS_POL;
    assign de     = dly_pipe[SYNC_DELAY].de;
    assign vblank = dly_pipe[SYNC_DELAY].vb;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench on a small 8x6 raster.
// dut_a: HS/VS active-high, SYNC_DELAY=2. dut_b: active-low, SYNC_DELAY=0.
module tb_vga_timing_gen;

    logic       clk;
    logic       rst;
    logic       pix_en;
    logic [3:0] a_hc, a_vc, b_hc, b_vc;
    logic       a_hs, a_vs, a_de, a_vb, a_ls, a_fs;
    logic       b_hs, b_vs, b_de, b_vb, b_ls, b_fs;

    int checks = 0;
    int errors = 0;
    int n      = 0;   // pix_en steps since last reset
    bit adv    = 0;   // previous edge advanced the counters
    int fs_cnt = 0;
    int ls_cnt = 0;

    vga_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(4), .SYNC_DELAY(2)
    ) dut_a (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .hcount(a_hc), .vcount(a_vc), .hsync(a_hs), .vsync(a_vs),
        .de(a_de), .vblank(a_vb), .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(4), .SYNC_DELAY(0)
    ) dut_b (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .hcount(b_hc), .vcount(b_vc), .hsync(b_hs), .vsync(b_vs),
        .de(b_de), .vblank(b_vb), .line_start(b_ls), .frame_start(b_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b (step %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic chkw(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d (step %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected {hs,vs,de,vb} (active-high) seen d pixel steps after position.
    function automatic logic [3:0] exp_dec(input int steps, input int d);
        int m, h, v;
        if (steps < d) return 4'b0000;
        m = steps - d;
        h = m % 8;
        v = (m / 8) % 6;
        return {(h >= 5 && h < 7), (v == 4), (h < 4 && v < 3), (v >= 3)};
    endfunction

    task automatic check_all(input string tag);
        logic [3:0] da, db;
        logic       ls, fs;
        da = exp_dec(n, 3);
        db = exp_dec(n, 1);
        ls = adv && (n % 8 == 0);
        fs = adv && (n % 48 == 0);
        chkw({tag, ".a_h"}, a_hc, 4'(n % 8));
        chkw({tag, ".a_v"}, a_vc, 4'((n / 8) % 6));
        chkw({tag, ".b_h"}, b_hc, 4'(n % 8));
        chkw({tag, ".b_v"}, b_vc, 4'((n / 8) % 6));
        chk1({tag, ".a_hs"}, a_hs, da[3]);
        chk1({tag, ".a_vs"}, a_vs, da[2]);
        chk1({tag, ".a_de"}, a_de, da[1]);
        chk1({tag, ".a_vb"}, a_vb, da[0]);
        chk1({tag, ".b_hs"}, b_hs, ~db[3]);
        chk1({tag, ".b_vs"}, b_vs, ~db[2]);
        chk1({tag, ".b_de"}, b_de, db[1]);
        chk1({tag, ".b_vb"}, b_vb, db[0]);
        chk1({tag, ".a_ls"}, a_ls, ls);
        chk1({tag, ".a_fs"}, a_fs, fs);
        chk1({tag, ".b_ls"}, b_ls, ls);
        chk1({tag, ".b_fs"}, b_fs, fs);
    endtask

    task automatic step(input logic pe, input string tag);
        pix_en = pe;
        @(posedge clk);
        #1;
        adv = pe;
        if (pe) n++;
        if (a_fs) fs_cnt++;
        if (a_ls) ls_cnt++;
        check_all(tag);
    endtask

    task automatic do_reset(input logic pe);
        rst    = 1'b1;
        pix_en = pe;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n   = 0;
        adv = 0;
        check_all("rst");
    endtask

    initial begin
        rst    = 1'b1;
        pix_en = 1'b0;

        // Reset with pix_en high: reset wins, everything inactive.
        do_reset(1'b1);
        do_reset(1'b1);
        chkw("rst_a_h", a_hc, 4'd0);
        chk1("rst_a_hs", a_hs, 1'b0);
        chk1("rst_b_hs", b_hs, 1'b1);
        chk1("rst_b_vs", b_vs, 1'b1);

        // hsync on dut_a goes active 3 steps after hcount=5, for 2 steps.
        repeat (5) step(1'b1, "hs");
        chk1("hs_pre", a_hs, 1'b0);
        repeat (3) step(1'b1, "hs");
        chk1("hs_on0", a_hs, 1'b1);
        step(1'b1, "hs");
        chk1("hs_on1", a_hs, 1'b1);
        step(1'b1, "hs");
        chk1("hs_off", a_hs, 1'b0);

        // Two full frames at full rate.
        do_reset(1'b0);
        fs_cnt = 0;
        ls_cnt = 0;
        repeat (96) step(1'b1, "run");
        chki("frame_cnt", fs_cnt, 2);
        chki("line_cnt", ls_cnt, 12);

        // 1-in-4 pixel rate: holds between steps, strobes still 1 clk.
        ls_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            repeat (3) step(1'b0, "sparse");
            step(1'b1, "sparse");
        end
        chki("sparse_lines", ls_cnt, 8);

        // Long gap mid-line: nothing moves.
        while (n % 8 != 2) step(1'b1, "pregap");
        repeat (1000) step(1'b0, "gap");

        // Mid-frame reset at (3,2) restarts silently at (0,0).
        while (n % 48 != 19) step(1'b1, "premid");
        chkw("mid_h", a_hc, 4'd3);
        chkw("mid_v", a_vc, 4'd2);
        do_reset(1'b1);
        chkw("mrst_h", a_hc, 4'd0);
        chkw("mrst_v", a_vc, 4'd0);
        chk1("mrst_ls", a_ls, 1'b0);
        chk1("mrst_fs", a_fs, 1'b0);
        chk1("mrst_b_hs", b_hs, 1'b1);
        chk1("mrst_b_vs", b_vs, 1'b1);
        chk1("mrst_b_de", b_de, 1'b0);
        fs_cnt = 0;
        repeat (47) step(1'b1, "refr");
        chki("refr_none", fs_cnt, 0);
        step(1'b1, "refr");
        chki("refr_one", fs_cnt, 1);

        // Wrap corner from (7,5).
        repeat (47) step(1'b1, "towrap");
        chkw("pre_h", a_hc, 4'd7);
        chkw("pre_v", a_vc, 4'd5);
        step(1'b1, "wrap");
        chkw("wrap_h", a_hc, 4'd0);
        chkw("wrap_v", a_vc, 4'd0);
        chk1("wrap_ls", a_ls, 1'b1);
        chk1("wrap_fs", a_fs, 1'b1);
        chk1("wrap_a_vb", a_vb, 1'b1);
        chk1("wrap_b_vb", b_vb, 1'b1);
        step(1'b1, "wrap");
        chk1("wrap1_b_vb", b_vb, 1'b0);
        chk1("wrap1_a_vb", a_vb, 1'b1);
        step(1'b1, "wrap");
        chk1("wrap2_a_vb", a_vb, 1'b1);
        step(1'b1, "wrap");
        chk1("wrap3_a_vb", a_vb, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
